byte_fifo: RTL and testbench

Synchronous byte FIFO that buffers parallel bytes assembled by the serial-to-parallel shift stage and hands them to the downstream consumer. The write side accepts one byte per strobe on `to_fifo_data`. The read side returns bytes in arrival order with a registered output. Full, empty, occupancy and sticky overflow/underflow flags are provided for the controllers on both sides.

---
 rtl/byte_fifo.sv | 70 +++++++
 tb/tb_byte_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with registered read data and sticky error flags
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] to_fifo_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Pointer MSB is a wrap bit: equal indices with differing wrap bits means full.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count  = wr_ptr - rd_ptr;

  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // Storage is deliberately not reset; stale contents are never visible through rd_data.
  always_ff @(posedge clk_50) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= to_fifo_data;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_data  <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
      if (wr_en && full && !rd_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_fifo.sv
// tb/tb_byte_fifo.sv - directed self-checking bench for byte_fifo
module tb_byte_fifo;

  logic       clk_50 = 1'b0;
  logic       reset  = 1'b1;
  logic       wr_en  = 1'b0;
  logic [7:0] to_fifo_data = 8'h00;
  logic       rd_en  = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  byte_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .wr_en        (wr_en),
    .to_fifo_data (to_fifo_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_11_88();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      to_fifo_data = 8'(8'h11 * i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain_11_88(input string tag);
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk({tag, "_data"}, rd_data, 8'(8'h11 * i));
      chk({tag, "_valid"}, rd_valid, 1'b1);
    end
    rd_en = 1'b0;
    step();
    chk({tag, "_valid_off"}, rd_valid, 1'b0);
    chk({tag, "_empty"}, empty, 1'b1);
  endtask

  initial begin
    logic [7:0] exp_b;

    // reset
    do_reset();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_underflow", underflow, 1'b0);

    // fill and drain
    fill_11_88();
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 4'd8);
    drain_11_88("drain1");

    // overflow: dropped byte never appears
    fill_11_88();
    wr_en = 1'b1;
    to_fifo_data = 8'h99;
    step();
    wr_en = 1'b0;
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_count", count, 4'd8);
    chk("ovf_full", full, 1'b1);
    drain_11_88("drain_ovf");
    chk("ovf_sticky", overflow, 1'b1);

    // simultaneous read/write while full
    do_reset();
    fill_11_88();
    wr_en = 1'b1;
    rd_en = 1'b1;
    to_fifo_data = 8'hAA;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rw_full_data", rd_data, 8'h11);
    chk("rw_full_valid", rd_valid, 1'b1);
    chk("rw_full_full", full, 1'b1);
    chk("rw_full_ovf", overflow, 1'b0);
    chk("rw_full_count", count, 4'd8);
    rd_en = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      step();
      exp_b = (i == 9) ? 8'hAA : 8'(8'h11 * i);
      chk("rw_full_drain", rd_data, exp_b);
    end
    rd_en = 1'b0;
    step();
    chk("rw_full_empty", empty, 1'b1);

    // underflow with simultaneous write into empty FIFO
    chk("pre_unf", underflow, 1'b0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    to_fifo_data = 8'h5A;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("unf_flag", underflow, 1'b1);
    chk("unf_valid", rd_valid, 1'b0);
    chk("unf_count", count, 4'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("unf_read_data", rd_data, 8'h5A);
    chk("unf_read_valid", rd_valid, 1'b1);

    // 20 write/read pairs across pointer wrap
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1;
      to_fifo_data = 8'(8'h40 + k);
      step();
      wr_en = 1'b0;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("wrap_data", rd_data, 8'(8'h40 + k));
    end
    chk("wrap_empty", empty, 1'b1);

    // mid-operation asynchronous reset
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1;
      to_fifo_data = 8'(8'hC0 + k);
      step();
    end
    wr_en = 1'b0;
    chk("mid_count_pre", count, 4'd3);
    #4;
    reset = 1'b1;
    #1;
    chk("mid_rst_count", count, 4'd0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_unf", underflow, 1'b0);
    repeat (2) @(posedge clk_50);
    #1;
    reset = 1'b0;
    wr_en = 1'b1;
    to_fifo_data = 8'h3C;
    step();
    wr_en = 1'b0;
    chk("post_rst_count", count, 4'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("post_rst_data", rd_data, 8'h3C);
    chk("post_rst_valid", rd_valid, 1'b1);
    step();
    chk("post_rst_empty", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
